// File: rtl/timing_mgr_pkg.sv
// Shared types and constants for the sensor timing manager.
// The TOUT state exists only when TIMING_MGR_TIMEOUT_EN is defined.
package timing_mgr_pkg;

   localparam int DEF_NUM_CH  = 6;
   localparam int DEF_CNT_W   = 16;
   localparam int DEF_RATIO_W = 16;

`ifdef TIMING_MGR_TIMEOUT_EN
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACQ  = 2'd1,
      DONE = 2'd2,
      TOUT = 2'd3
   } tm_state_e;
`else
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACQ  = 2'd1,
      DONE = 2'd2
   } tm_state_e;
`endif

   // LSB position of channel ch inside the flattened ch_time bus.
   function automatic int ch_lsb(input int ch, input int cnt_w);
      return ch * cnt_w;
   endfunction

endpackage

// File: rtl/sensor_timing_manager_if.sv
// Signal bundle between the sensor timing manager and its environment.
// No valid/ready pairs here: trigger and sched_isr are single-cycle pulses, all other signals are levels sampled every clk.
interface sensor_timing_manager_if
   import timing_mgr_pkg::*;
#(
   parameter int NUM_CH  = DEF_NUM_CH,
   parameter int CNT_W   = DEF_CNT_W,
   parameter int RATIO_W = DEF_RATIO_W
) ();

   logic                      event_qualifier;
   logic [RATIO_W-1:0]        user_ratio;
   logic [NUM_CH-1:0]         en_bits;
   logic [NUM_CH-1:0]         done;
   logic [CNT_W-1:0]          timeout_cycles;
   logic                      status_clr;
   logic                      trigger;
   logic [NUM_CH-1:0]         en;
   logic                      sched_isr;
   logic                      all_done;
   logic                      busy;
   logic [NUM_CH*CNT_W-1:0]   ch_time;
   logic [NUM_CH-1:0]         captured;
   logic                      timeout_flag;
   logic                      overrun_flag;
   tm_state_e                 fsm_state;

   modport master (
      output event_qualifier, user_ratio, en_bits, done, timeout_cycles, status_clr,
      input  trigger, en, sched_isr, all_done, busy, ch_time, captured,
             timeout_flag, overrun_flag, fsm_state
   );

   modport slave (
      input  event_qualifier, user_ratio, en_bits, done, timeout_cycles, status_clr,
      output trigger, en, sched_isr, all_done, busy, ch_time, captured,
             timeout_flag, overrun_flag, fsm_state
   );

endinterface

// File: rtl/tm_channel_capture.sv
// One sensor channel: done rising-edge detect, captured bit and time-stamp register.
module tm_channel_capture
   import timing_mgr_pkg::*;
#(
   parameter int CNT_W = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             done,
   input  logic             enable,
   input  logic             acq,
   input  logic             clear,
   input  logic [CNT_W-1:0] tcnt,
   output logic             captured,
   output logic [CNT_W-1:0] ch_time
);

   logic done_q;
   logic rise;

   assign rise = done & ~done_q;

   // A new window (clear) wins over an edge arriving in the same cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         done_q   <= 1'b0;
         captured <= 1'b0;
         ch_time  <= '0;
      end else begin
         done_q <= done;
         if (clear) begin
            captured <= 1'b0;
         end else if (acq && enable && !captured && rise) begin
            captured <= 1'b1;
            ch_time  <= tcnt;
         end
      end
   end

endmodule

// File: rtl/sensor_timing_manager.sv
// Sensor acquisition timing: carrier-ratio trigger, per-channel capture, completion interrupt.
// Define TIMING_MGR_TIMEOUT_EN to build the acquisition watchdog and TOUT state.
module sensor_timing_manager
   import timing_mgr_pkg::*;
#(
   parameter int NUM_CH  = DEF_NUM_CH,
   parameter int CNT_W   = DEF_CNT_W,
   parameter int RATIO_W = DEF_RATIO_W
) (
   input logic                    clk,
   input logic                    rst,
   sensor_timing_manager_if.slave bus
);

   tm_state_e                 state, state_nxt;
   logic [RATIO_W-1:0]        cnt;
   logic                      trigger_q;
   logic [CNT_W-1:0]          tcnt;
   logic [NUM_CH-1:0]         captured;
   logic [NUM_CH*CNT_W-1:0]   ch_time_all;
   logic                      all_cap;
   logic                      in_acq;
   logic                      isr_nxt;
   logic                      sched_isr_q;
   logic                      overrun_q;
   logic                      timeout_q;
   logic                      wd_expire;

   // Carrier divider: the compare takes priority over counting, so ratio 0 triggers every cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt       <= '0;
         trigger_q <= 1'b0;
      end else if (cnt == bus.user_ratio) begin
         cnt       <= '0;
         trigger_q <= 1'b1;
      end else begin
         if (bus.event_qualifier) cnt <= cnt + RATIO_W'(1);
         trigger_q <= 1'b0;
      end
   end

   assign in_acq  = (state == ACQ);
   assign all_cap = &(captured | ~bus.en_bits);

`ifdef TIMING_MGR_TIMEOUT_EN
   assign wd_expire = in_acq && !all_cap && (tcnt == bus.timeout_cycles);
`else
   logic unused_timeout;
   assign unused_timeout = ^bus.timeout_cycles;
   assign wd_expire      = 1'b0;
`endif

   always_comb begin
      state_nxt = state;
      if (trigger_q) begin
         state_nxt = ACQ;
      end else begin
         case (state)
            ACQ: begin
               if (all_cap)        state_nxt = DONE;
`ifdef TIMING_MGR_TIMEOUT_EN
               else if (wd_expire) state_nxt = TOUT;
`endif
            end
            default: state_nxt = state;
         endcase
      end
      // Leaving ACQ always means entering DONE or TOUT.
      isr_nxt = in_acq && (state_nxt != ACQ);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         sched_isr_q <= 1'b0;
         tcnt        <= '0;
         overrun_q   <= 1'b0;
         timeout_q   <= 1'b0;
      end else begin
         state       <= state_nxt;
         sched_isr_q <= isr_nxt;
         if (trigger_q)
            tcnt <= '0;
         else if (in_acq && (tcnt != {CNT_W{1'b1}}))
            tcnt <= tcnt + CNT_W'(1);
         // Sticky flags: a same-cycle set beats status_clr.
         if (trigger_q && in_acq) overrun_q <= 1'b1;
         else if (bus.status_clr) overrun_q <= 1'b0;
         if (wd_expire)           timeout_q <= 1'b1;
         else if (bus.status_clr) timeout_q <= 1'b0;
      end
   end

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      tm_channel_capture #(.CNT_W(CNT_W)) u_cap (
         .clk      (clk),
         .rst      (rst),
         .done     (bus.done[g]),
         .enable   (bus.en_bits[g]),
         .acq      (in_acq),
         .clear    (trigger_q),
         .tcnt     (tcnt),
         .captured (captured[g]),
         .ch_time  (ch_time_all[ch_lsb(g, CNT_W) +: CNT_W])
      );
   end

   assign bus.trigger      = trigger_q;
   assign bus.en           = bus.en_bits;
   assign bus.sched_isr    = sched_isr_q;
   assign bus.all_done     = (state == DONE);
   assign bus.busy         = in_acq;
   assign bus.ch_time      = ch_time_all;
   assign bus.captured     = captured;
   assign bus.timeout_flag = timeout_q;
   assign bus.overrun_flag = overrun_q;
   assign bus.fsm_state    = state;

endmodule

// File: doc/sensor_timing_manager.md
SENSOR_TIMING_MANAGER -- requirements
Module: sensor_timing_manager

Interface
REQ-001 SHALL have parameter NUM_CH, default 6, meaning the number of sensor channels (1..16).
REQ-002 SHALL have parameter CNT_W, default 16, meaning the width of the time and timeout counters.
REQ-003 SHALL have parameter RATIO_W, default 16, meaning the width of the carrier-ratio counter.
REQ-004 SHALL have one clock and an asynchronous, active-high reset: clk  in  1  clock; rst  in  1  asynchronous active-high reset.
REQ-005 SHALL have the remaining ports below.
- event_qualifier  in  1  PWM carrier event.
- user_ratio  in  RATIO_W  events per trigger.
- en_bits  in  NUM_CH  channel enables.
- done  in  NUM_CH  per-channel done level.
- timeout_cycles  in  CNT_W  acquisition watchdog limit.
- status_clr  in  1  clears sticky flags.
- trigger  out  1  acquisition start pulse.
- en  out  NUM_CH  equals en_bits.
- sched_isr  out  1  one-cycle completion interrupt.
- all_done  out  1  all enabled channels captured this window.
- busy  out  1  FSM in ACQ.
- ch_time  out  NUM_CH*CNT_W  per-channel capture, channel i at bits [i*CNT_W +: CNT_W].
- captured  out  NUM_CH  per-channel captured-this-window mask.
- timeout_flag  out  1  sticky watchdog expiry.
- overrun_flag  out  1  sticky trigger-during-ACQ.

Function
REQ-006 SHALL use ratio counter cnt: if cnt==user_ratio then cnt<=0 and trigger<=1; else if event_qualifier then cnt<=cnt+1 and trigger<=0; else hold cnt and trigger<=0.
REQ-007 SHALL, with user_ratio==0, assert trigger on every cycle after reset release.
REQ-008 SHALL implement FSM states IDLE, ACQ, DONE, TOUT.
REQ-009 SHALL make FSM transitions as follows.
- Any state, trigger=1: next state ACQ; captured<=0; time counter tcnt<=0.
- ACQ: all enabled channels captured -> DONE.
- ACQ: watchdog expiry (REQ-014) -> TOUT.
- DONE and TOUT: hold until the next trigger.
REQ-010 SHALL increment tcnt by 1 per cycle in ACQ, saturating at 2^CNT_W-1 (no wrap), and hold it in other states.
REQ-011 SHALL, when done[i] has a rising edge (registered edge detect) while in ACQ with en_bits[i]=1 and captured[i]=0, load ch_time[i]<=tcnt and set captured[i]<=1.
- Later edges within the same window SHALL be ignored.
- A trigger whose cycle coincides with an edge SHALL take priority, and that edge SHALL NOT be captured.
REQ-012 SHALL drive all_done=1 iff the FSM is in DONE.
REQ-013 SHALL pulse sched_isr for exactly one cycle on each entry to DONE or TOUT.
REQ-014 SHALL detect watchdog expiry when tcnt==timeout_cycles in ACQ while not all enabled channels are captured; on expiry it SHALL set timeout_flag, leaving ch_time of uncaptured channels unchanged.
REQ-015 SHALL set overrun_flag when trigger=1 while the FSM is in ACQ; the new window still starts.
REQ-016 SHALL, when en_bits==0 on a trigger, enter ACQ and then DONE on the next cycle, with sched_isr one cycle later.
REQ-017 SHALL clear timeout_flag and overrun_flag on status_clr=1; a same-cycle set SHALL win over the clear.
REQ-018 SHALL sample en_bits continuously, so that a channel disabled mid-window no longer blocks DONE.

Reset
REQ-019 SHALL, while rst=1, force the following values: cnt=0, tcnt=0, trigger=0, sched_isr=0, FSM=IDLE, captured=0, ch_time=0, all flags=0, busy=0, all_done=0, edge-detect registers=0.
REQ-020 SHALL, when rst is asserted mid-acquisition, abort the acquisition immediately with no sched_isr, and resume normal operation on the first clk after rst falls.

Configuration
REQ-021 SHALL, with TIMING_MGR_TIMEOUT_EN defined, implement REQ-014 and the TOUT state.
REQ-022 SHALL, without TIMING_MGR_TIMEOUT_EN, omit TOUT, ignore timeout_cycles (port retained), and tie timeout_flag to 0; ACQ then waits indefinitely.

Structure
REQ-023 SHALL place the FSM state enum, default parameter constants and the ch_time slicing helper in shared package timing_mgr_pkg.
REQ-024 SHALL instantiate sub-module tm_channel_capture once per channel (edge detect, captured bit, ch_time register).

Verification
REQ-025 SHALL verify capture timing: user_ratio=3 and 4 event pulses -> trigger at cycle T; done[2] rising at T+10 with en_bits=0x04 -> ch_time[2]=9, sched_isr pulse at T+11 or later, all_done=1.
REQ-026 SHALL verify multi-channel completion: en_bits=0x3F, done[0..5] staggered -> DONE only after the last edge, ch_time values strictly ordered, and exactly one sched_isr.
REQ-027 SHALL verify the watchdog: timeout_cycles=20, en_bits=0x03, only done[0] rising -> TOUT, timeout_flag=1, captured=0x01, one sched_isr; status_clr -> flag=0.
REQ-028 SHALL verify overrun: user_ratio=0 -> trigger every cycle, overrun_flag=1, all_done never set.
REQ-029 SHALL verify mid-window reset: rst pulsed 5 cycles into ACQ -> all outputs zero and no sched_isr.
REQ-030 SHALL verify the configuration build: with TIMING_MGR_TIMEOUT_EN undefined, rerunning REQ-027 -> busy stays 1 and timeout_flag=0.
